// File: rtl/gpu_pkg.sv
// Shared GPU definitions: coordinate/colour widths, raster FSM states and the
// pixel record passed from the rasterizer to the frame-buffer writer.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  // Two extra bits hold the sign plus the doubling in e2 = 2*err.
  localparam int ERR_BITS     = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;

  typedef logic signed [ERR_BITS-1:0] err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRAW,
    ST_DONE,
    ST_WAIT_LOW
  } raster_state_t;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } pixel_t;

endpackage

// File: rtl/gpu_bresenham_step.sv
// One combinational Bresenham step: next pixel position and error term.
module gpu_bresenham_step
  import gpu_pkg::*;
(
  input  logic [WIDTH_BITS-1:0]  cur_x,
  input  logic [HEIGHT_BITS-1:0] cur_y,
  input  err_t                   err,
  input  err_t                   dx,
  input  err_t                   dy,
  input  logic                   sx_neg,
  input  logic                   sy_neg,
  output logic [WIDTH_BITS-1:0]  next_x,
  output logic [HEIGHT_BITS-1:0] next_y,
  output err_t                   next_err
);

  err_t e2;
  logic step_x;
  logic step_y;

  always_comb begin
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    // Both terms come from the pre-step err, so a diagonal step adds dx+dy.
    next_err = err + (step_x ? dy : err_t'(0)) + (step_y ? dx : err_t'(0));
    next_x   = cur_x;
    next_y   = cur_y;
    if (step_x) next_x = sx_neg ? cur_x - WIDTH_BITS'(1) : cur_x + WIDTH_BITS'(1);
    if (step_y) next_y = sy_neg ? cur_y - HEIGHT_BITS'(1) : cur_y + HEIGHT_BITS'(1);
  end

endmodule

// File: rtl/gpu_line_rasterizer.sv
// Line rasterizer: latches a line request from the decoder and emits one
// Bresenham pixel per valid/ready handshake, then pulses finished_o.
module gpu_line_rasterizer
  import gpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    draw_line_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    px_ready_i,
  output logic                    px_valid_o,
  output logic [WIDTH_BITS-1:0]   px_x_o,
  output logic [HEIGHT_BITS-1:0]  px_y_o,
  output logic [CHANNEL_BITS-1:0] px_r_o,
  output logic [CHANNEL_BITS-1:0] px_g_o,
  output logic [CHANNEL_BITS-1:0] px_b_o,
  output logic                    busy_o,
  output logic                    finished_o
);

  raster_state_t          state;
  pixel_t                 start_q;
  logic [WIDTH_BITS-1:0]  x2_q;
  logic [HEIGHT_BITS-1:0] y2_q;
  pixel_t                 pix;
  err_t                   dx, dy, err;
  logic                   sx_neg, sy_neg;

  logic [WIDTH_BITS-1:0]  adx;
  logic [HEIGHT_BITS-1:0] ady;
  err_t                   dx_c, dy_c;
  logic [WIDTH_BITS-1:0]  next_x;
  logic [HEIGHT_BITS-1:0] next_y;
  err_t                   next_err;

  always_comb begin
    adx  = (x2_q >= start_q.x) ? x2_q - start_q.x : start_q.x - x2_q;
    ady  = (y2_q >= start_q.y) ? y2_q - start_q.y : start_q.y - y2_q;
    dx_c = err_t'(adx);
    dy_c = -err_t'(ady);
  end

  gpu_bresenham_step u_step (
    .cur_x    (pix.x),
    .cur_y    (pix.y),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .next_x   (next_x),
    .next_y   (next_y),
    .next_err (next_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_q    <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      pix        <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      px_valid_o <= 1'b0;
      finished_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (draw_line_i) begin
          start_q <= '{x: x1_i, y: y1_i, r: r_i, g: g_i, b: b_i};
          x2_q    <= x2_i;
          y2_q    <= y2_i;
          state   <= ST_SETUP;
        end
        ST_SETUP: begin
          dx         <= dx_c;
          dy         <= dy_c;
          err        <= dx_c + dy_c;
          sx_neg     <= !(start_q.x < x2_q);
          sy_neg     <= !(start_q.y < y2_q);
          pix        <= start_q;
          px_valid_o <= 1'b1;
          state      <= ST_DRAW;
        end
        ST_DRAW: if (px_ready_i) begin
          if (pix.x == x2_q && pix.y == y2_q) begin
            px_valid_o <= 1'b0;
            finished_o <= 1'b1;
            state      <= ST_DONE;
          end else begin
            pix.x <= next_x;
            pix.y <= next_y;
            err   <= next_err;
          end
        end
        ST_DONE: begin
          finished_o <= 1'b0;
          state      <= ST_WAIT_LOW;
        end
        // Decoder holds draw_line_i high; wait for it to drop before re-arming.
        ST_WAIT_LOW: if (!draw_line_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign px_x_o = pix.x;
  assign px_y_o = pix.y;
  assign px_r_o = pix.r;
  assign px_g_o = pix.g;
  assign px_b_o = pix.b;

endmodule

// File: tb/tb_gpu_line_rasterizer.sv
// Directed bench for gpu_line_rasterizer with an expected-pixel scoreboard.
module tb_gpu_line_rasterizer;
  import gpu_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    draw_line_i;
  logic [WIDTH_BITS-1:0]   x1_i, x2_i;
  logic [HEIGHT_BITS-1:0]  y1_i, y2_i;
  logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic                    px_ready_i;
  logic                    px_valid_o;
  logic [WIDTH_BITS-1:0]   px_x_o;
  logic [HEIGHT_BITS-1:0]  px_y_o;
  logic [CHANNEL_BITS-1:0] px_r_o, px_g_o, px_b_o;
  logic                    busy_o;
  logic                    finished_o;

  gpu_line_rasterizer dut (
    .clk         (clk),
    .rst         (rst),
    .draw_line_i (draw_line_i),
    .x1_i        (x1_i),
    .y1_i        (y1_i),
    .x2_i        (x2_i),
    .y2_i        (y2_i),
    .r_i         (r_i),
    .g_i         (g_i),
    .b_i         (b_i),
    .px_ready_i  (px_ready_i),
    .px_valid_o  (px_valid_o),
    .px_x_o      (px_x_o),
    .px_y_o      (px_y_o),
    .px_r_o      (px_r_o),
    .px_g_o      (px_g_o),
    .px_b_o      (px_b_o),
    .busy_o      (busy_o),
    .finished_o  (finished_o)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  pixel_t exp_q[$];
  int     hs_cnt, fin_cnt, fin_tick, tick_no;
  logic [CHANNEL_BITS-1:0] cr, cg, cb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_px(input int x, input int y);
    pixel_t p;
    p.x = WIDTH_BITS'(x);
    p.y = HEIGHT_BITS'(y);
    p.r = cr;
    p.g = cg;
    p.b = cb;
    exp_q.push_back(p);
  endtask

  // Sample at the falling edge, then step past the next rising edge.
  task automatic tick();
    pixel_t got;
    @(negedge clk);
    tick_no++;
    if (px_valid_o && px_ready_i) begin
      got.x = px_x_o;
      got.y = px_y_o;
      got.r = px_r_o;
      got.g = px_g_o;
      got.b = px_b_o;
      hs_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_pixel: observed %0h expected none", got);
      end
      if (exp_q.size() != 0) check("pixel", got, exp_q.pop_front());
    end
    if (finished_o) begin
      fin_cnt++;
      fin_tick = tick_no;
      check("fin_without_valid", px_valid_o, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int x1, input int y1, input int x2, input int y2);
    x1_i = WIDTH_BITS'(x1);
    y1_i = HEIGHT_BITS'(y1);
    x2_i = WIDTH_BITS'(x2);
    y2_i = HEIGHT_BITS'(y2);
    r_i = cr; g_i = cg; b_i = cb;
    draw_line_i = 1'b1;
    hs_cnt = 0; fin_cnt = 0; fin_tick = 0; tick_no = 0;
    tick();
    check("valid_lat1", px_valid_o, 0);
    // Later input changes must not affect the captured line.
    x1_i = '1; y1_i = '1; x2_i = '1; y2_i = '1;
    r_i = '0; g_i = '0; b_i = '0;
    tick();
    check("valid_lat2", px_valid_o, 1);
    tick_no = 0;
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget && fin_cnt == 0; i++) tick();
    tick();
    check("finished_once", fin_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic end_line();
    draw_line_i = 1'b0;
    tick();
    tick();
    check("idle_after_drop", busy_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    draw_line_i = 1'b0;
    x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0;
    r_i = '0; g_i = '0; b_i = '0;
    px_ready_i = 1'b1;
    hs_cnt = 0; fin_cnt = 0; fin_tick = 0; tick_no = 0;
    tick();
    tick();
    check("rst_valid", px_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fin", finished_o, 0);
    check("rst_pix", {px_x_o, px_y_o, px_r_o, px_g_o, px_b_o}, 0);
    rst = 1'b0;
    tick();

    // Horizontal line, consecutive pixels and finish timing.
    cr = 8'hAA; cg = 8'hBB; cb = 8'hCC;
    for (int i = 0; i < 4; i++) push_px(i, 0);
    start_line(0, 0, 3, 0);
    wait_finish(20);
    check("horiz_hs", hs_cnt, 4);
    check("horiz_fin_tick", fin_tick, 5);
    end_line();

    // Degenerate single point.
    cr = 8'h12; cg = 8'h34; cb = 8'h56;
    push_px(7, 9);
    start_line(7, 9, 7, 9);
    wait_finish(10);
    check("point_hs", hs_cnt, 1);
    check("point_fin_tick", fin_tick, 2);
    end_line();

    // Reverse diagonal.
    cr = 8'h01; cg = 8'h02; cb = 8'h03;
    for (int i = 5; i >= 2; i--) push_px(i, i);
    start_line(5, 5, 2, 2);
    wait_finish(20);
    check("rdiag_hs", hs_cnt, 4);
    end_line();

    // Steep line.
    cr = 8'hF0; cg = 8'h0F; cb = 8'h5A;
    push_px(0, 0); push_px(0, 1); push_px(1, 2); push_px(1, 3);
    start_line(0, 0, 1, 3);
    wait_finish(20);
    check("steep_hs", hs_cnt, 4);
    end_line();

    // Backpressure on the second pixel.
    cr = 8'h11; cg = 8'h22; cb = 8'h33;
    for (int i = 0; i < 3; i++) push_px(i, 0);
    start_line(0, 0, 2, 0);
    tick();
    px_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", px_valid_o, 1);
      check("stall_xy", {px_x_o, px_y_o}, {10'd1, 9'd0});
    end
    px_ready_i = 1'b1;
    wait_finish(20);
    check("bp_hs", hs_cnt, 3);
    end_line();

    // Reset mid-line, then a fresh line from its own start point.
    cr = 8'h44; cg = 8'h55; cb = 8'h66;
    for (int i = 0; i < 10; i++) push_px(i, 0);
    start_line(0, 0, 9, 0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", px_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    exp_q.delete();
    draw_line_i = 1'b0;
    tick();
    tick();
    check("rst_mid_nofin", fin_cnt, 0);
    check("rst_mid_hs", hs_cnt, 4);
    rst = 1'b0;
    tick();
    cr = 8'h77; cg = 8'h88; cb = 8'h99;
    for (int i = 3; i <= 5; i++) push_px(i, 1);
    start_line(3, 1, 5, 1);
    wait_finish(20);
    check("after_rst_hs", hs_cnt, 3);

    // draw_line_i held high after finish must not re-trigger.
    for (int i = 0; i < 8; i++) tick();
    check("held_fin", fin_cnt, 1);
    check("held_hs", hs_cnt, 3);
    check("held_busy", busy_o, 1);
    check("held_valid", px_valid_o, 0);
    end_line();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_line_rasterizer.md
Name: gpu_line_rasterizer

Overview:
Sits directly downstream of the GPU command decoder. Consumes the latched endpoint and colour registers plus the draw_line level, and walks the line with integer Bresenham, one pixel per accepted handshake, toward the frame-buffer writer. Pulses finished_o when the line completes; the decoder uses this pulse to return to its restart state.

Parameters:
WIDTH_BITS, 10, x-coordinate width (from gpu_definitions).
HEIGHT_BITS, 9, y-coordinate width.
CHANNEL_BITS, 8, per-colour-channel width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
draw_line_i  input  1  level from decoder; high = line request pending
x1_i  input  WIDTH_BITS  start x
y1_i  input  HEIGHT_BITS  start y
x2_i  input  WIDTH_BITS  end x
y2_i  input  HEIGHT_BITS  end y
r_i/g_i/b_i  input  CHANNEL_BITS each  line colour
px_ready_i  input  1  frame-buffer writer can accept a pixel
px_valid_o  output  1  pixel on px_* is valid
px_x_o  output  WIDTH_BITS  pixel x
px_y_o  output  HEIGHT_BITS  pixel y
px_r_o/px_g_o/px_b_o  output  CHANNEL_BITS each  pixel colour
busy_o  output  1  high in any state other than IDLE
finished_o  output  1  single-cycle completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. Internal registers 0.
- States: IDLE, SETUP, DRAW, DONE, WAIT_LOW.
- IDLE: if draw_line_i=1, capture x1,y1,x2,y2 and colour into internal registers, then go to SETUP. Later input changes do not affect the line in progress.
- SETUP (1 cycle):
  - dx = |x2-x1|; dy = -|y2-y1|.
  - sx = +1 if x1<x2, else -1. sy = +1 if y1<y2, else -1.
  - err = dx+dy.
  - cur_x=x1, cur_y=y1.
  - Go to DRAW.
- Arithmetic: dx, dy, err and e2 are signed, max(WIDTH_BITS,HEIGHT_BITS)+2 bits wide. No overflow is possible for in-range coordinates.
- DRAW:
  - px_valid_o=1 with px_x_o=cur_x, px_y_o=cur_y and the captured colour.
  - Outputs hold stable while px_ready_i=0.
  - On a handshake (valid&ready), if cur==endpoint, go to DONE.
  - Otherwise step, with e2=2*err:
    - if e2>=dy: err+=dy, cur_x+=sx.
    - if e2<=dx: err+=dx, cur_y+=sy.
    - Both updates use the pre-step err and sum when both fire.
- Throughput: one pixel per cycle when px_ready_i stays high. First px_valid_o is 2 cycles after IDLE samples draw_line_i=1. Pixel count = max(dx,|dy|)+1.
- DONE: finished_o=1 for exactly one cycle, px_valid_o=0; go to WAIT_LOW.
- WAIT_LOW: stay until draw_line_i=0, then go to IDLE. This prevents a re-trigger from the decoder's held level.
- Degenerate line (x1=x2, y1=y2): exactly one pixel, then DONE.
- Ready asserted with valid low is ignored.
- Reset mid-line: return to IDLE immediately, drop px_valid_o, no finished_o pulse.
- draw_line_i falling mid-line: ignored; the line completes.

Decomposition:
- Shared package gpu_pkg holds:
  - WIDTH_BITS/HEIGHT_BITS/CHANNEL_BITS constants (currently in gpu_definitions);
  - the raster state enum typedef;
  - a pixel struct {x, y, r, g, b}, also reused by the frame-buffer writer.
- One natural sub-module: gpu_bresenham_step. It is combinational: from cur_x, cur_y, err, dx, dy, sx, sy it produces next_x, next_y, next_err. The FSM instantiates it so the step can be unit-tested alone.

Test Plan:
1. Horizontal line, (0,0)->(3,0), ready tied high -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; first valid 2 cycles after draw_line_i rises; finished_o one cycle after the last handshake.
2. Single point, (7,9)->(7,9), colour 0x12/0x34/0x56 -> exactly one pixel (7,9) with that colour, then finished_o.
3. Reverse diagonal, (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2).
4. Steep line, (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3).
5. Backpressure on (0,0)->(2,0), px_ready_i low for 3 cycles on the second pixel -> (1,0) held stable while stalled; total 3 handshakes; no duplicates or skips.
6. Reset mid-line on (0,0)->(9,0), rst pulsed after 4 pixels -> valid drops immediately, no finished_o; the next request draws from its own x1. Separately, draw_line_i held high after finished_o -> no second draw until it drops.
